// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: opcodes, FSM states, shift-op classifier.
// No logic of its own; latency and backpressure do not apply.
// Imported by usr_step and universal_shift_register_seq.
package usr_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Opcodes that step once per clock for amt clocks; the rest finish in one edge.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
               (op == OP_ROL) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// Single-step next-value function for one shift/rotate bit position.
// Combinational, zero latency; non-shift opcodes pass the register value through.
// No backpressure; the caller decides when the result is registered.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] a_next
);

    always_comb begin
        a_next = a;
        unique case (op)
            OP_SHR:  a_next = {msb_in, a[WIDTH-1:1]};
            OP_SHL:  a_next = {a[WIDTH-2:0], lsb_in};
            OP_ROR:  a_next = {a[0], a[WIDTH-1:1]};
            OP_ROL:  a_next = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ASR:  a_next = {a[WIDTH-1], a[WIDTH-1:1]};
            default: a_next = a;
        endcase
    end

endmodule

// File: rtl/universal_shift_register_seq.sv
// Universal shift/rotate register with start/busy/done command interface.
// Latency: HOLD/LOAD/CLR in 1 clock, shifts in amt clocks; done pulses the cycle after the last step.
// Backpressure: start is ignored while busy=1 (no queueing); start in the done cycle is accepted.
module universal_shift_register_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] I_par,
    input  logic             MSB_in,
    input  logic             LSB_in,
    output logic [WIDTH-1:0] A_par,
    output logic             SO_r,
    output logic             SO_l,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             done_q, done_d;
    logic [2:0]       step_op;
    logic [WIDTH-1:0] a_step;

    // The first step happens at the accepting edge, so IDLE uses the live opcode.
    assign step_op = (state_q == ST_SHIFT) ? op_q : op;

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op     (step_op),
        .a      (a_q),
        .msb_in (MSB_in),
        .lsb_in (LSB_in),
        .a_next (a_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift(op)) begin
                        if (amt != '0) begin
                            a_d = a_step;
                        end
                        if (amt > AMT_ONE) begin
                            state_d = ST_SHIFT;
                            op_d    = op;
                            cnt_d   = amt - AMT_ONE;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        if (op == OP_LOAD) begin
                            a_d = I_par;
                        end else if (op == OP_CLR) begin
                            a_d = '0;
                        end
                        done_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                a_d   = a_step;
                cnt_d = cnt_q - AMT_ONE;
                if (cnt_q == AMT_ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            a_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            done_q  <= done_d;
        end
    end

    assign A_par = a_q;
    assign SO_r  = a_q[0];
    assign SO_l  = a_q[WIDTH-1];
    assign busy  = (state_q == ST_SHIFT);
    assign done  = done_q;

endmodule

// File: tb/tb_universal_shift_register_seq.sv
// Directed-vector bench for universal_shift_register_seq (WIDTH=8, AMT_W=4).
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_universal_shift_register_seq;

    logic       CLK = 1'b0;
    logic       Clear = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [3:0] amt = 4'd0;
    logic [7:0] I_par = 8'h00;
    logic       MSB_in = 1'b0;
    logic       LSB_in = 1'b0;
    logic [7:0] A_par;
    logic       SO_r, SO_l, busy, done;

    int checks = 0;
    int errors = 0;
    bit run_mon = 1'b0;

    universal_shift_register_seq #(.WIDTH(8), .AMT_W(4)) dut (
        .CLK    (CLK),
        .Clear  (Clear),
        .start  (start),
        .op     (op),
        .amt    (amt),
        .I_par  (I_par),
        .MSB_in (MSB_in),
        .LSB_in (LSB_in),
        .A_par  (A_par),
        .SO_r   (SO_r),
        .SO_l   (SO_l),
        .busy   (busy),
        .done   (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmd(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        op    = o;
        amt   = a;
        I_par = d;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (run_mon) chk("busy_done_excl", 32'(busy & done), 32'd0);
    end

    initial begin
        int n;
        int done_seen;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_a", 32'(A_par), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge CLK);
        Clear = 1'b1;
        run_mon = 1'b1;

        // LOAD A5: one edge, single done pulse, never busy
        cmd(3'b011, 4'd0, 8'hA5);
        chk("load_a", 32'(A_par), 32'hA5);
        chk("load_done", 32'(done), 32'd1);
        chk("load_busy", 32'(busy), 32'd0);
        tick();
        chk("load_done_clr", 32'(done), 32'd0);

        // ROL by 3 from A5
        cmd(3'b101, 4'd3, 8'h00);
        chk("rol_s1", 32'(A_par), 32'h4B);
        chk("rol_b1", 32'(busy), 32'd1);
        chk("rol_d1", 32'(done), 32'd0);
        tick();
        chk("rol_s2", 32'(A_par), 32'h96);
        chk("rol_b2", 32'(busy), 32'd1);
        tick();
        chk("rol_s3", 32'(A_par), 32'h2D);
        chk("rol_b3", 32'(busy), 32'd0);
        chk("rol_d3", 32'(done), 32'd1);
        tick();
        chk("rol_d4", 32'(done), 32'd0);

        // ASR by 2 from 96
        cmd(3'b011, 4'd0, 8'h96);
        cmd(3'b110, 4'd2, 8'h00);
        chk("asr_s1", 32'(A_par), 32'hCB);
        tick();
        chk("asr_s2", 32'(A_par), 32'hE5);
        chk("asr_done", 32'(done), 32'd1);

        // SHR by 4 from 0F with MSB_in=1; SO_r sampled before each step
        MSB_in = 1'b1;
        cmd(3'b011, 4'd0, 8'h0F);
        chk("shr_so0", 32'(SO_r), 32'd1);
        chk("shr_sol0", 32'(SO_l), 32'd0);
        cmd(3'b001, 4'd4, 8'h00);
        chk("shr_so1", 32'(SO_r), 32'd1);
        tick();
        chk("shr_so2", 32'(SO_r), 32'd1);
        tick();
        chk("shr_so3", 32'(SO_r), 32'd1);
        tick();
        chk("shr_a", 32'(A_par), 32'hF0);
        chk("shr_done", 32'(done), 32'd1);
        chk("shr_sol", 32'(SO_l), 32'd1);
        MSB_in = 1'b0;

        // ROR by 9 from 01, with an SHL start during busy that must be ignored
        cmd(3'b011, 4'd0, 8'h01);
        cmd(3'b100, 4'd9, 8'h00);
        chk("ror_s1", 32'(A_par), 32'h80);
        @(negedge CLK);
        op = 3'b010; amt = 4'd1; I_par = 8'hFF; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        chk("ign_a", 32'(A_par), 32'h40);
        chk("ign_busy", 32'(busy), 32'd1);
        repeat (7) tick();
        chk("ror_a", 32'(A_par), 32'h80);
        chk("ror_busy", 32'(busy), 32'd0);
        chk("ror_done", 32'(done), 32'd1);

        // Back-to-back: start issued in the done cycle is accepted
        cmd(3'b011, 4'd0, 8'h3C);
        chk("b2b_a", 32'(A_par), 32'h3C);
        chk("b2b_done", 32'(done), 32'd1);

        cmd(3'b010, 4'd0, 8'h00);
        chk("shl0_a", 32'(A_par), 32'h3C);
        chk("shl0_done", 32'(done), 32'd1);
        cmd(3'b000, 4'd5, 8'h00);
        chk("hold_a", 32'(A_par), 32'h3C);
        chk("hold_done", 32'(done), 32'd1);
        cmd(3'b111, 4'd0, 8'h00);
        chk("clr_a", 32'(A_par), 32'h00);
        chk("clr_done", 32'(done), 32'd1);

        // SHL by 10 (> WIDTH) from FF fills with zeros; done must come after edge 10
        LSB_in = 1'b0;
        cmd(3'b011, 4'd0, 8'hFF);
        cmd(3'b010, 4'd10, 8'h00);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("big_cycles", 32'(n), 32'd9);
        chk("big_a", 32'(A_par), 32'h00);

        // Abort mid-SHIFT with Clear: immediate zero, no done for the aborted command
        cmd(3'b011, 4'd0, 8'hFF);
        cmd(3'b010, 4'd8, 8'h00);
        tick();
        @(negedge CLK);
        Clear = 1'b0;
        #1;
        chk("abort_a", 32'(A_par), 32'h00);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        @(negedge CLK);
        Clear = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        cmd(3'b011, 4'd0, 8'h5A);
        chk("abort_ready", 32'(A_par), 32'h5A);
        chk("abort_ready_done", 32'(done), 32'd1);

        run_mon = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
